// File: rtl/lpc_autocorr.sv
// Autocorrelation engine: buffers one N-sample frame, then produces r[0..P] with a single MAC.
// Optional macro AUTOCORR_SAT_EN saturates the shifted accumulator to signed RW range.
module lpc_autocorr #(
    parameter int unsigned N     = 256,
    parameter int unsigned P     = 10,
    parameter int unsigned DW    = 16,
    parameter int unsigned AW    = 40,
    parameter int unsigned RW    = 32,
    parameter int unsigned SHIFT = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DW-1:0]          in_data,
    output logic                   r_we,
    output logic [$clog2(P+1)-1:0] r_addr,
    output logic [RW-1:0]          r_data,
    output logic                   done,
    input  logic                   ack,
    output logic                   busy
);

    localparam int unsigned CW = $clog2(N);
    localparam int unsigned KW = $clog2(P+1);
    localparam logic [CW-1:0] NLast = CW'(N - 1);
    localparam logic [KW-1:0] KLast = KW'(P);

    typedef enum logic [1:0] {StLoad, StMac, StWrite, StDone} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [CW-1:0]         n_q, n_d;
    logic [KW-1:0]         k_q, k_d;
    logic signed [AW-1:0]  acc_q, acc_d;
    logic                  r_we_q, r_we_d;
    logic [KW-1:0]         r_addr_q, r_addr_d;
    logic [RW-1:0]         r_data_q, r_data_d;
    logic                  wr_en;

    logic signed [DW-1:0]   frame_mem [N];
    logic signed [DW-1:0]   mul_a, mul_b;
    logic signed [2*DW-1:0] prod;
    logic signed [AW-1:0]   prod_ext, acc_next;
    logic [CW-1:0]          k_ext;
    logic [RW-1:0]          r_red;

    assign k_ext    = CW'(k_q);
    assign mul_a    = frame_mem[n_q];
    assign mul_b    = frame_mem[n_q - k_ext];
    assign prod     = mul_a * mul_b;
    assign prod_ext = {{(AW-2*DW){prod[2*DW-1]}}, prod};
    // First cycle of each lag restarts the sum rather than accumulating.
    assign acc_next = (n_q == k_ext) ? prod_ext : acc_q + prod_ext;

`ifdef AUTOCORR_SAT_EN
    logic signed [AW-1:0] shifted;
    logic [AW-RW:0]       upper;
    assign shifted = acc_next >>> SHIFT;
    assign upper   = shifted[AW-1:RW-1];
    always_comb begin
        r_red = shifted[RW-1:0];
        if (!(&upper) && |upper) begin
            r_red = shifted[AW-1] ? {1'b1, {(RW-1){1'b0}}} : {1'b0, {(RW-1){1'b1}}};
        end
    end
`else
    always_comb begin
        r_red = RW'(acc_next >>> SHIFT);
    end
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        n_d      = n_q;
        k_d      = k_q;
        acc_d    = acc_q;
        r_we_d   = 1'b0;
        r_addr_d = r_addr_q;
        r_data_d = r_data_q;
        wr_en    = 1'b0;
        unique case (state_q)
            StLoad: begin
                if (in_valid) begin
                    wr_en = 1'b1;
                    if (cnt_q == NLast) begin
                        state_d = StMac;
                        cnt_d   = '0;
                        n_d     = '0;
                        k_d     = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StMac: begin
                acc_d = acc_next;
                if (n_q == NLast) begin
                    // Register the write so r_we/r_addr/r_data line up with the WRITE cycle.
                    state_d  = StWrite;
                    r_we_d   = 1'b1;
                    r_addr_d = k_q;
                    r_data_d = r_red;
                end else begin
                    n_d = n_q + 1'b1;
                end
            end
            StWrite: begin
                if (k_q == KLast) begin
                    state_d = StDone;
                end else begin
                    k_d     = k_q + 1'b1;
                    n_d     = k_ext + 1'b1;
                    state_d = StMac;
                end
            end
            StDone: begin
                if (ack) begin
                    state_d = StLoad;
                    cnt_d   = '0;
                end
            end
            default: state_d = StLoad;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StLoad;
            cnt_q    <= '0;
            n_q      <= '0;
            k_q      <= '0;
            acc_q    <= '0;
            r_we_q   <= 1'b0;
            r_addr_q <= '0;
            r_data_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            n_q      <= n_d;
            k_q      <= k_d;
            acc_q    <= acc_d;
            r_we_q   <= r_we_d;
            r_addr_q <= r_addr_d;
            r_data_q <= r_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            frame_mem[cnt_q] <= in_data;
        end
    end

    assign in_ready = (state_q == StLoad);
    assign busy     = (state_q == StMac) || (state_q == StWrite);
    assign done     = (state_q == StDone);
    assign r_we     = r_we_q;
    assign r_addr   = r_addr_q;
    assign r_data   = r_data_q;

endmodule

// File: tb/tb_lpc_autocorr.sv
// Directed bench for lpc_autocorr with N=8, P=2; expected lag sums are hand-computed.
module tb_lpc_autocorr;

    localparam int unsigned N = 8;
    localparam int unsigned P = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic        r_we;
    logic [1:0]  r_addr;
    logic [31:0] r_data;
    logic        done;
    logic        ack = 1'b0;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int nwr = 0;
    int lat;
    logic [31:0] got [4];
    logic [15:0] s [8];

    lpc_autocorr #(.N(N), .P(P), .DW(16), .AW(40), .RW(32), .SHIFT(0)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .r_we(r_we), .r_addr(r_addr), .r_data(r_data),
        .done(done), .ack(ack), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (r_we) begin
            got[r_addr] = r_data;
            nwr = nwr + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_capture();
        nwr = 0;
        for (int i = 0; i < 4; i++) got[i] = 32'hDEADBEEF;
    endtask

    task automatic send_frame(input bit gaps);
        clear_capture();
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = s[i];
            @(posedge clk); #1;
            if (gaps && i < 7) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!done && cycles < 200) begin
            @(posedge clk); #1;
            cycles++;
        end
    endtask

    task automatic check_frame(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                               input logic [31:0] e2);
        check({tag, "_r0"}, got[0], e0);
        check({tag, "_r1"}, got[1], e1);
        check({tag, "_r2"}, got[2], e2);
        check({tag, "_nwr"}, nwr, 3);
    endtask

    task automatic do_ack();
        ack = 1'b1;
        @(posedge clk); #1;
        ack = 1'b0;
        check("ack_done_clr", done, 0);
        check("ack_ready", in_ready, 1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", in_ready, 1);
        check("rst_we", r_we, 0);
        check("rst_addr", r_addr, 0);
        check("rst_data", r_data, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0;

        // ack in LOAD is ignored
        ack = 1'b1;
        @(posedge clk); #1;
        ack = 1'b0;
        check("ackload_ready", in_ready, 1);
        check("ackload_done", done, 0);

        // Frame of ones: 8,7,6 with 24-cycle latency
        for (int i = 0; i < 8; i++) s[i] = 16'd1;
        send_frame(1'b0);
        check("ones_ready_low", in_ready, 0);
        check("ones_busy", busy, 1);
        wait_done(lat);
        check("ones_latency", lat, 24);
        check("ones_busy_done", busy, 0);
        check_frame("ones", 32'd8, 32'd7, 32'd6);
        repeat (20) @(posedge clk);
        #1;
        check("hold_done", done, 1);
        check("hold_ready", in_ready, 0);
        do_ack();

        // [1,2,0..] with ack pulsed during MAC (ignored)
        for (int i = 0; i < 8; i++) s[i] = 16'd0;
        s[0] = 16'd1; s[1] = 16'd2;
        send_frame(1'b0);
        ack = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        ack = 1'b0;
        check("ackmac_busy", busy, 1);
        check("ackmac_ready", in_ready, 0);
        wait_done(lat);
        check("p12_latency", lat + 2, 24);
        check_frame("p12", 32'd5, 32'd2, 32'd0);
        do_ack();

        // [3,-1,0..]
        s[0] = 16'd3; s[1] = 16'hFFFF;
        send_frame(1'b0);
        wait_done(lat);
        check_frame("p3m1", 32'd10, 32'hFFFFFFFD, 32'd0);
        do_ack();

        // Full-scale samples: saturation vs wrap
        for (int i = 0; i < 8; i++) s[i] = 16'h7FFF;
        send_frame(1'b0);
        wait_done(lat);
`ifdef AUTOCORR_SAT_EN
        check_frame("max", 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF);
`else
        check_frame("max", 32'hFFF80008, 32'hBFF90007, 32'h7FFA0006);
`endif
        do_ack();

        // Ones with every-other-cycle gaps
        for (int i = 0; i < 8; i++) s[i] = 16'd1;
        send_frame(1'b1);
        check("gap_ready_low", in_ready, 0);
        wait_done(lat);
        check("gap_latency", lat, 24);
        check_frame("gap", 32'd8, 32'd7, 32'd6);
        do_ack();

        // Reset during MAC of lag 1 (lag 0 = 8 cycles, write = 1)
        send_frame(1'b0);
        repeat (10) @(posedge clk);
        #2;
        check("prereset_busy", busy, 1);
        reset = 1'b1;
        #1;
        check("midrst_we", r_we, 0);
        check("midrst_done", done, 0);
        check("midrst_ready", in_ready, 1);
        check("midrst_busy", busy, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        send_frame(1'b0);
        wait_done(lat);
        check("postrst_latency", lat, 24);
        check_frame("postrst", 32'd8, 32'd7, 32'd6);
        do_ack();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
